muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that produces the 64-bit results written into the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU in 32 iteration cycles, plus single-cycle MTHI/MTLO moves.
- Presents results on a HI/LO write interface: per-half write strobes and data that drive the HI/LO register's write inputs directly.
- Sits in the execute stage; the pipeline stalls on `busy` before issuing MFHI/MFLO or a new mul/div op.

---
 rtl/muldiv_unit.sv | 102 ++++++++++
 tb/tb_muldiv_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO feeding the HI/LO register write port
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             write_hi,
  output logic             write_lo,
  output logic [WIDTH-1:0] data_hi,
  output logic [WIDTH-1:0] data_lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0]    count;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, p_hi, p_lo;
  logic             accept, is_mul, a_neg, b_neg, ok, div0;
  logic [WIDTH-1:0] mag_a, mag_b, nxt_hi, nxt_lo, q_fix, r_fix, res_hi, res_lo;
  logic [WIDTH:0]   sum, trial;
  logic [2*WIDTH-1:0] prod, prod_fix;
  function automatic logic [WIDTH-1:0] magn(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction
  // WRITE also accepts so moves can issue every cycle
  assign accept = (state != RUN) && start && (op < 3'd6);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    if (state == RUN) state_nxt = (count == '0) ? WRITE : RUN;
    else if (accept)  state_nxt = op[2] ? WRITE : RUN;
  end
  always_comb busy = (state != IDLE);
  always_comb begin
    is_mul = ~op_r[1];
    a_neg  = ~op_r[0] & a_r[WIDTH-1];
    b_neg  = ~op_r[0] & b_r[WIDTH-1];
    mag_a  = a_neg ? -a_r : a_r;
    mag_b  = b_neg ? -b_r : b_r;
    sum    = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag_a} : '0);
    trial  = {p_hi, p_lo[WIDTH-1]} - {1'b0, mag_b};
    ok     = ~trial[WIDTH];
    nxt_hi = is_mul ? sum[WIDTH:1] : ok ? trial[WIDTH-1:0] : {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
    nxt_lo = is_mul ? {sum[0], p_lo[WIDTH-1:1]} : {p_lo[WIDTH-2:0], ok};
    prod     = {nxt_hi, nxt_lo};
    prod_fix = (a_neg ^ b_neg) ? -prod : prod;
    q_fix    = (a_neg ^ b_neg) ? -nxt_lo : nxt_lo;
    r_fix    = a_neg ? -nxt_hi : nxt_hi;
    div0     = (b_r == '0);
    res_hi   = is_mul ? prod_fix[2*WIDTH-1:WIDTH] : div0 ? a_r : r_fix;
    res_lo   = is_mul ? prod_fix[WIDTH-1:0] : div0 ? '1 : q_fix;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count    <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      write_hi <= 1'b0;
      write_lo <= 1'b0;
      data_hi  <= '0;
      data_lo  <= '0;
    end else begin
      write_hi <= 1'b0;
      write_lo <= 1'b0;
      if (accept) begin
        op_r  <= op[1:0];
        a_r   <= in_a;
        b_r   <= in_b;
        count <= CW'(WIDTH - 1);
        p_hi  <= '0;
        p_lo  <= op[1] ? magn(in_a, ~op[0]) : magn(in_b, ~op[0]);
        if (op == 3'd4) begin
          write_hi <= 1'b1;
          data_hi  <= in_a;
        end
        if (op == 3'd5) begin
          write_lo <= 1'b1;
          data_lo  <= in_a;
        end
      end else if (state == RUN) begin
        p_hi  <= nxt_hi;
        p_lo  <= nxt_lo;
        count <= count - 1'b1;
        if (count == '0) begin
          write_hi <= 1'b1;
          write_lo <= 1'b1;
          data_hi  <= res_hi;
          data_lo  <= res_lo;
        end
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue checked by an independent write-port monitor
module tb_muldiv_unit;
  logic        clk = 1'b0, reset, start, busy, write_hi, write_lo;
  logic [2:0]  op;
  logic [31:0] in_a, in_b, data_hi, data_lo, model_hi, model_lo;
  int          cyc = 0, checks = 0, errors = 0;
  typedef struct {logic wh; logic wl; logic [31:0] dh; logic [31:0] dl; int at;} exp_t;
  exp_t sb[$];
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .busy(busy), .write_hi(write_hi), .write_lo(write_lo), .data_hi(data_hi), .data_lo(data_lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Record the write the DUT owes us; moves leave the other half at its held value
  task automatic push_exp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    if (o == 3'd4) model_hi = a;
    else if (o == 3'd5) model_lo = a;
    else begin
      model_hi = eh;
      model_lo = el;
    end
    e.wh = (o != 3'd5);
    e.wl = (o != 3'd4);
    e.dh = model_hi;
    e.dl = model_lo;
    e.at = cyc + (o[2] ? 0 : 32);
    sb.push_back(e);
  endtask
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    start = 1'b1;
    op = o;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a = ~a;
    in_b = ~b;
    if (push) push_exp(o, a, eh, el);
    chk("busy_rise", 32'(busy), 32'd1);
  endtask
  task automatic wait_done(input int n);
    repeat (n) @(posedge clk);
    #1;
    chk("busy_in_write", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("busy_fall", 32'(busy), 32'd0);
    chk("strobes_low_after", {30'd0, write_hi, write_lo}, 32'd0);
  endtask
  always @(negedge clk)
    if (write_hi || write_lo) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got hi=%b lo=%b at cycle %0d required none", write_hi, write_lo, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_hi", 32'(write_hi), 32'(e.wh));
        chk("write_lo", 32'(write_lo), 32'(e.wl));
        chk("data_hi", data_hi, e.dh);
        chk("data_lo", data_lo, e.dl);
        chk("strobe_cycle", 32'(cyc), 32'(e.at));
      end
    end
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 3'd0;
    in_a = '0;
    in_b = '0;
    model_hi = '0;
    model_lo = '0;
    #12 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write_hi", 32'(write_hi), 32'd0);
    chk("rst_write_lo", 32'(write_lo), 32'd0);
    chk("rst_data_hi", data_hi, 32'd0);
    chk("rst_data_lo", data_lo, 32'd0);
    do_op(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1); wait_done(32);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1); wait_done(32);
    do_op(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1); wait_done(32);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1); wait_done(32);
    do_op(3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b1); wait_done(32);
    do_op(3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1); wait_done(32);
    do_op(3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1); wait_done(32);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b1); wait_done(32);
    do_op(3'd3, 32'hF0000000, 32'd7, 32'd2, 32'h22492492, 1'b1); wait_done(32);
    do_op(3'd4, 32'h12345678, 32'd0, 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("move_busy_fall", 32'(busy), 32'd0);
    start = 1'b1;
    op = 3'd4;
    in_a = 32'hAAAA5555;
    @(posedge clk);
    #1;
    push_exp(3'd4, 32'hAAAA5555, 32'd0, 32'd0);
    op = 3'd5;
    in_a = 32'h5555AAAA;
    @(posedge clk);
    #1;
    push_exp(3'd5, 32'h5555AAAA, 32'd0, 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_busy_fall", 32'(busy), 32'd0);
    start = 1'b1;
    op = 3'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("invalid_op_idle", 32'(busy), 32'd0);
    do_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op = 3'd3;
    in_a = 32'd50;
    in_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(27);
    repeat (40) @(posedge clk);
    #1;
    do_op(3'd3, 32'd1000, 32'd9, 32'd0, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_data_hi", data_hi, 32'd0);
    chk("reset_data_lo", data_lo, 32'd0);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    repeat (40) @(posedge clk);
    #1;
    chk("post_reset_data_hi", data_hi, 32'd0);
    chk("post_reset_data_lo", data_lo, 32'd0);
    do_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1); wait_done(32);
    repeat (5) @(posedge clk);
    #1;
    chk("pending_writes", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
